// File: rtl/ha1588_avl_bridge.sv
// ha1588_avl_bridge
//   Avalon-MM slave front-end that shares one host bus across NUM_CH ha1588
//   register banks. The upper address bits select the bank, and the lower bits
//   select the register. Each access produces a one-cycle wr/rd strobe to the
//   selected bank. The host is stalled with waitrequest until the access
//   completes. Accesses to a non-existent bank, writes with partial byte
//   enables, and simultaneous read+write requests are rejected and counted.
//
// Ports
//   clk, rst              single clock, synchronous active-low reset
//   avs_*                 Avalon-MM slave (word addressed, 32-bit data)
//   ch_wr / ch_rd         one-hot single-cycle strobes, one bit per bank
//   ch_addr / ch_wdata    bank register address and write data (held)
//   ch_rdata              packed bank read data, bank k at [32k+31:32k]
//   err_cnt               saturating count of rejected accesses
module ha1588_avl_bridge #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned CH_AW           = 6,
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned RD_LATENCY      = 1,
    parameter int unsigned ADDR_IS_IN_WORD = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   avs_address,
    input  logic                    avs_write,
    input  logic                    avs_read,
    input  logic [31:0]             avs_writedata,
    input  logic [3:0]              avs_byteenable,
    output logic [31:0]             avs_readdata,
    output logic                    avs_readdatavalid,
    output logic                    avs_waitrequest,
    output logic [NUM_CH-1:0]       ch_wr,
    output logic [NUM_CH-1:0]       ch_rd,
    output logic [7:0]              ch_addr,
    output logic [31:0]             ch_wdata,
    input  logic [NUM_CH*32-1:0]    ch_rdata,
    output logic [7:0]              err_cnt
);

    localparam int unsigned SelW = ADDR_WIDTH - CH_AW;

    typedef enum logic [2:0] {StIdle, StWack, StRstb, StRwait, StRack} state_e;

    state_e            r_state;
    logic [SelW-1:0]   r_sel;
    logic [2:0]        r_cnt;
    logic [NUM_CH-1:0] r_ch_wr;
    logic [NUM_CH-1:0] r_ch_rd;
    logic [7:0]        r_ch_addr;
    logic [31:0]       r_ch_wdata;
    logic [31:0]       r_rdata;
    logic              r_rdv;
    logic [7:0]        r_err;

    logic [SelW-1:0]   w_sel;
    logic [CH_AW-1:0]  w_reg;
    logic [7:0]        w_reg8;
    logic [7:0]        w_ch_addr;
    logic              w_sel_ok;
    logic              w_wr_ok;
    logic [NUM_CH-1:0] w_onehot;
    logic [31:0]       w_rdsel;
    logic [7:0]        w_err_next;
    logic              w_ack;

    assign w_sel    = avs_address[ADDR_WIDTH-1:CH_AW];
    assign w_reg    = avs_address[CH_AW-1:0];
    assign w_reg8   = 8'(w_reg);
    // Byte addressing shifts the word index up by two; upper bits fall off.
    assign w_ch_addr = (ADDR_IS_IN_WORD != 0) ? w_reg8 : {w_reg8[5:0], 2'b00};
    assign w_sel_ok = (32'(w_sel) < NUM_CH);
    // A simultaneous read+write request is rejected as a bad write.
    assign w_wr_ok  = w_sel_ok && (avs_byteenable == 4'hF) && !avs_read;
    assign w_err_next = (r_err == 8'hFF) ? 8'hFF : r_err + 8'd1;
    assign w_ack    = (r_state == StWack) || (r_state == StRack);

    always_comb begin
        w_onehot = '0;
        w_rdsel  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_onehot[k] = (32'(w_sel) == k);
            if (32'(r_sel) == k) begin
                w_rdsel = ch_rdata[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_sel      <= '0;
            r_cnt      <= '0;
            r_ch_wr    <= '0;
            r_ch_rd    <= '0;
            r_ch_addr  <= '0;
            r_ch_wdata <= '0;
            r_rdata    <= '0;
            r_rdv      <= 1'b0;
            r_err      <= '0;
        end else begin
            // Strobes and readdatavalid are single-cycle pulses by default.
            r_ch_wr <= '0;
            r_ch_rd <= '0;
            r_rdv   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (avs_write || avs_read) begin
                        r_ch_addr  <= w_ch_addr;
                        r_ch_wdata <= avs_writedata;
                        r_sel      <= w_sel;
                        if (avs_write) begin
                            r_state <= StWack;
                            if (w_wr_ok) begin
                                r_ch_wr <= w_onehot;
                            end else begin
                                r_err <= w_err_next;
                            end
                        end else if (w_sel_ok) begin
                            r_ch_rd <= w_onehot;
                            r_cnt   <= 3'(RD_LATENCY);
                            r_state <= StRstb;
                        end else begin
                            // Bad channel read completes immediately with zero data.
                            r_err   <= w_err_next;
                            r_rdata <= '0;
                            r_rdv   <= 1'b1;
                            r_state <= StRack;
                        end
                    end
                end
                StRstb, StRwait: begin
                    // Sample bank data RD_LATENCY cycles after the read strobe.
                    if (r_cnt == 3'd0) begin
                        r_rdata <= w_rdsel;
                        r_rdv   <= 1'b1;
                        r_state <= StRack;
                    end else begin
                        r_cnt   <= r_cnt - 3'd1;
                        r_state <= StRwait;
                    end
                end
                StWack, StRack: r_state <= StIdle;
                default:        r_state <= StIdle;
            endcase
        end
    end

    assign avs_waitrequest   = !rst || ((avs_read || avs_write) && !w_ack);
    assign avs_readdata      = r_rdata;
    assign avs_readdatavalid = r_rdv;
    assign ch_wr             = r_ch_wr;
    assign ch_rd             = r_ch_rd;
    assign ch_addr           = r_ch_addr;
    assign ch_wdata          = r_ch_wdata;
    assign err_cnt           = r_err;

endmodule
